ser2par_8: RTL and testbench
============================

SER2PAR_8 -- requirements
Module: ser2par_8

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all listed ports SHALL exist in both build configurations.
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 din_vld  input  1  serial bit valid; upstream registered bit-stream stage drives it.
REQ-005 din  input  1  serial data bit, MSB first.
REQ-006 din_rdy  output  1  block accepts din this cycle.
REQ-007 dout_rdy  input  1  downstream accepts dout this cycle.
REQ-008 dout_vld  output  1  dout holds a complete word.
REQ-009 dout  output  8  assembled parallel word.
REQ-010 parity_err  output  1  parity mismatch flag for the word on dout; constant 0 when parity is compiled out.

Function
REQ-011 A bit SHALL be accepted on a rising edge where din_vld=1 and din_rdy=1; no other edge SHALL change the shift register or bit counter.
REQ-012 Accepted data bits SHALL shift left into an internal 8-bit register: first accepted bit lands in dout[7], eighth in dout[0].
REQ-013 Bit counter SHALL count accepted bits 0..N-1 (N=8, or 9 with parity) and wrap to 0 on the edge accepting bit N-1.
REQ-014 On the edge accepting the final bit, dout SHALL load the completed word and dout_vld SHALL be 1 from the next cycle (latency 1 cycle after the final bit).
REQ-015 dout and parity_err SHALL stay stable while dout_vld=1 and dout_rdy=0.
REQ-016 dout_vld SHALL clear on the edge where dout_vld=1 and dout_rdy=1, unless a new word loads on the same edge.
REQ-017 Same-edge output handshake and final-bit acceptance: new word SHALL load, dout_vld SHALL stay 1, no word lost or duplicated.
REQ-018 din_rdy SHALL be 1 except when the counter is at N-1, dout_vld=1 and dout_rdy=0 (output busy, final bit stalls).
REQ-019 Non-final bits SHALL be accepted regardless of output occupancy, so the next word assembles while the previous one waits.
REQ-020 din_rdy SHALL be combinational from counter, dout_vld and dout_rdy only, never from din_vld.
REQ-021 Gaps in din_vld SHALL pause assembly with no timeout; partial words are retained.

Reset
REQ-022 rst=1 at a rising edge SHALL set dout=8'h00, dout_vld=0, parity_err=0, bit counter=0, shift register=0.
REQ-023 Reset mid-word SHALL discard partial bits; first accepted bit after reset is MSB of a new word.
REQ-024 Reset with dout_vld=1 SHALL drop the pending word regardless of dout_rdy.
REQ-025 din_rdy SHALL be 1 in the first cycle after reset release.

Configuration
REQ-026 Macro SER2PAR_PARITY_CHK_EN defined: N=9; ninth accepted bit is an odd-parity bit over the 8 data bits; parity_err loads with dout, 1 when the XOR of the nine bits is 0; word delivered regardless.
REQ-027 Macro SER2PAR_PARITY_CHK_EN undefined: N=8, no parity bit consumed, parity_err tied 0.

Verification
REQ-028 Reset, then bits 1,0,1,0,0,1,0,1 with din_vld=1 and dout_rdy=1 -> dout=8'hA5, dout_vld=1 for exactly one cycle, one cycle after the 8th bit.
REQ-029 dout_rdy=0, send 8'h3C then 7 bits of 8'hF0 -> din_rdy=1 through bit 7, 0 at bit 8; dout stays 8'h3C; raising dout_rdy -> 8'hF0 loads next edge, dout_vld unbroken.
REQ-030 Continuous din_vld, dout_rdy=1, words 8'h01,8'h80,8'hFF -> three dout_vld pulses 8 cycles apart, values in order, din_rdy never 0.
REQ-031 rst after 4 bits of 8'hC3, then full 8'h5A -> only 8'h5A appears; reset forces dout=8'h00, dout_vld=0.
REQ-032 din_vld toggling 1/0 every cycle for 8'h96 -> dout=8'h96 after 16 cycles, no extra bits captured.
REQ-033 Macro defined: 8'h07 + parity bit 0 -> parity_err=0; 8'h07 + parity bit 1 -> parity_err=1, dout=8'h07 both cases.

Source files
------------

// File: rtl/ser2par_8.sv
// MSB-first serial-to-parallel converter with valid/ready on both sides.
// Define SER2PAR_PARITY_CHK_EN to consume and check a trailing odd-parity bit.
module ser2par_8 (
   input  logic       clk,
   input  logic       rst,
   input  logic       din_vld,
   input  logic       din,
   output logic       din_rdy,
   input  logic       dout_rdy,
   output logic       dout_vld,
   output logic [7:0] dout,
   output logic       parity_err
);

`ifdef SER2PAR_PARITY_CHK_EN
   localparam logic [3:0] LAST = 4'd8;
`else
   localparam logic [3:0] LAST = 4'd7;
`endif

   logic [3:0] cnt_q, cnt_d;
   logic [7:0] sr_q, sr_d;
   logic [7:0] dout_q, dout_d;
   logic       vld_q, vld_d;
   logic       perr_q, perr_d;
   logic       last, acc, load;

   assign last    = (cnt_q == LAST);
   // Only the final bit stalls, and only while the output slot is occupied.
   assign din_rdy = !(last && vld_q && !dout_rdy);
   assign acc     = din_vld && din_rdy;
   assign load    = acc && last;

   always_comb begin
      cnt_d  = cnt_q;
      sr_d   = sr_q;
      dout_d = dout_q;
      vld_d  = vld_q;
      perr_d = perr_q;
      if (vld_q && dout_rdy)
         vld_d = 1'b0;
      if (acc) begin
         cnt_d = last ? 4'd0 : cnt_q + 4'd1;
`ifdef SER2PAR_PARITY_CHK_EN
         if (!last)
            sr_d = {sr_q[6:0], din};
`else
         sr_d = {sr_q[6:0], din};
`endif
      end
      if (load) begin
         vld_d = 1'b1;
`ifdef SER2PAR_PARITY_CHK_EN
         dout_d = sr_q;
         perr_d = ~(^sr_q ^ din);
`else
         dout_d = {sr_q[6:0], din};
         perr_d = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= 4'd0;
         sr_q   <= 8'h00;
         dout_q <= 8'h00;
         vld_q  <= 1'b0;
         perr_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         sr_q   <= sr_d;
         dout_q <= dout_d;
         vld_q  <= vld_d;
         perr_q <= perr_d;
      end
   end

   assign dout_vld   = vld_q;
   assign dout       = dout_q;
   assign parity_err = perr_q;

endmodule

// File: tb/tb_ser2par_8.sv
// Scoreboard bench for ser2par_8: stimulus pushes expected words,
// a negedge monitor pops them on every output handshake.
module tb_ser2par_8;

`ifdef SER2PAR_PARITY_CHK_EN
   localparam int NB = 9;
`else
   localparam int NB = 8;
`endif

   logic       clk = 1'b0;
   logic       rst, din_vld, din, dout_rdy;
   logic       din_rdy, dout_vld, parity_err;
   logic [7:0] dout;

   int n_chk = 0, n_pass = 0;
   int m_chk = 0, m_pass = 0;
   int cyc = 0;
   int stalled = 0;
   logic [8:0] exp_q[$];
   int pop_cyc[$];

   ser2par_8 dut (
      .clk(clk), .rst(rst),
      .din_vld(din_vld), .din(din), .din_rdy(din_rdy),
      .dout_rdy(dout_rdy), .dout_vld(dout_vld),
      .dout(dout), .parity_err(parity_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      logic [8:0] e;
      if (!rst && dout_vld && dout_rdy) begin
         m_chk++;
         pop_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            $display("FAIL mon_unexpected: got %h, no word expected",
                     {parity_err, dout});
         end else begin
            e = exp_q.pop_front();
            if ({parity_err, dout} == e) m_pass++;
            else $display("FAIL mon_word: got %h, want %h",
                          {parity_err, dout}, e);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
   endtask

   function automatic logic bit_of(input logic [7:0] w, input int i);
      if (i < 8) return w[7-i];
      return ~^w;
   endfunction

   task automatic send_bit(input logic b);
      int g;
      g = 0;
      din_vld = 1'b1;
      din = b;
      while (!din_rdy && g < 64) begin
         @(posedge clk); #1;
         g++;
      end
      if (g > 0) stalled++;
      if (!din_rdy) chk("accept_timeout", 32'd0, 32'd1);
      else begin
         @(posedge clk); #1;
      end
   endtask

   task automatic send_raw(input logic [7:0] w);
      for (int i = 0; i < NB; i++) send_bit(bit_of(w, i));
   endtask

   task automatic send_word(input logic [7:0] w);
      exp_q.push_back({1'b0, w});
      send_raw(w);
   endtask

   task automatic tick;
      @(posedge clk); #1;
   endtask

   initial begin
      int n0;
      rst = 1'b1; din_vld = 1'b0; din = 1'b0; dout_rdy = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_dout", dout, 8'h00);
      chk("rst_vld", dout_vld, 1'b0);
      chk("rst_perr", parity_err, 1'b0);
      rst = 1'b0;
      chk("rst_rdy", din_rdy, 1'b1);

      // single word, one-cycle pulse
      send_word(8'hA5);
      chk("a5_vld", dout_vld, 1'b1);
      chk("a5_dout", dout, 8'hA5);
      din_vld = 1'b0;
      tick;
      chk("a5_pulse", dout_vld, 1'b0);

      // back-to-back words
      n0 = pop_cyc.size();
      stalled = 0;
      send_word(8'h01);
      send_word(8'h80);
      send_word(8'hFF);
      din_vld = 1'b0;
      tick;
      chk("b2b_pops", pop_cyc.size() - n0, 3);
      if (pop_cyc.size() >= n0 + 3) begin
         chk("b2b_gap1", pop_cyc[n0+1] - pop_cyc[n0], NB);
         chk("b2b_gap2", pop_cyc[n0+2] - pop_cyc[n0+1], NB);
      end
      chk("b2b_nostall", stalled, 0);

      // output backpressure: final bit stalls, rest assemble
      dout_rdy = 1'b0;
      send_word(8'h3C);
      exp_q.push_back({1'b0, 8'hF0});
      stalled = 0;
      for (int i = 0; i < NB - 1; i++) send_bit(bit_of(8'hF0, i));
      chk("bp_nostall", stalled, 0);
      din_vld = 1'b1;
      din = bit_of(8'hF0, NB - 1);
      #1;
      chk("bp_final_stall", din_rdy, 1'b0);
      repeat (3) tick;
      chk("bp_hold_dout", dout, 8'h3C);
      chk("bp_hold_vld", dout_vld, 1'b1);
      chk("bp_hold_rdy", din_rdy, 1'b0);
      dout_rdy = 1'b1;
      #1;
      chk("bp_release_rdy", din_rdy, 1'b1);
      tick;
      din_vld = 1'b0;
      chk("bp_unbroken", dout_vld, 1'b1);
      chk("bp_new_word", dout, 8'hF0);
      tick;

      // reset mid-word discards partial bits
      for (int i = 0; i < 4; i++) send_bit(bit_of(8'hC3, i));
      din_vld = 1'b0;
      rst = 1'b1;
      tick;
      chk("mid_rst_dout", dout, 8'h00);
      chk("mid_rst_vld", dout_vld, 1'b0);
      rst = 1'b0;

      // reset drops a pending word
      dout_rdy = 1'b0;
      send_raw(8'h77);
      din_vld = 1'b0;
      chk("pend_vld", dout_vld, 1'b1);
      rst = 1'b1;
      dout_rdy = 1'b1;
      tick;
      chk("pend_drop", dout_vld, 1'b0);
      rst = 1'b0;
      chk("pend_rdy", din_rdy, 1'b1);
      send_word(8'h5A);
      din_vld = 1'b0;
      chk("rst_5a", dout, 8'h5A);
      tick;

      // gapped din_vld
      exp_q.push_back({1'b0, 8'h96});
      for (int i = 0; i < NB; i++) begin
         send_bit(bit_of(8'h96, i));
         if (i < NB - 1) begin
            din_vld = 1'b0;
            din = ~din;
            tick;
         end
      end
      din_vld = 1'b0;
      chk("gap_dout", dout, 8'h96);
      tick;
      send_word(8'h3A);
      din_vld = 1'b0;
      chk("gap_next", dout, 8'h3A);
      tick;

`ifdef SER2PAR_PARITY_CHK_EN
      exp_q.push_back({1'b0, 8'h07});
      for (int i = 0; i < 8; i++) send_bit(bit_of(8'h07, i));
      send_bit(1'b0);
      chk("par_ok", parity_err, 1'b0);
      exp_q.push_back({1'b1, 8'h07});
      for (int i = 0; i < 8; i++) send_bit(bit_of(8'h07, i));
      send_bit(1'b1);
      chk("par_err", parity_err, 1'b1);
      chk("par_dout", dout, 8'h07);
      din_vld = 1'b0;
`endif

      repeat (3) tick;
      chk("sb_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass + m_pass, n_chk + m_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: sim time limit reached");
      $fatal(1);
   end

endmodule
